// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller: writes pixels round-robin into four line buffers and
// streams a 3-row window from the three oldest complete lines.
module line_buffer_ctrl #(
  parameter int IMAGE_WIDTH = 512,
  parameter int NUM_LB      = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_valid,
  output logic        o_ready,
  output logic [7:0]  o_lb_wr_data,
  output logic [3:0]  o_lb_wr_valid,
  output logic [3:0]  o_lb_rd_en,
  input  logic [23:0] i_lb_data0,
  input  logic [23:0] i_lb_data1,
  input  logic [23:0] i_lb_data2,
  input  logic [23:0] i_lb_data3,
  output logic [71:0] o_window,
  output logic        o_window_valid,
  output logic        o_intr
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int CNT_W = $clog2(NUM_LB * IMAGE_WIDTH + 1);
  localparam int LB_W  = $clog2(NUM_LB);

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(NUM_LB * IMAGE_WIDTH);
  localparam logic [CNT_W-1:0] RD_LVL   = CNT_W'(3 * IMAGE_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);

  typedef enum logic {
    IDLE,
    RD_LINE
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [COL_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LB_W-1:0]  wr_lb_q, wr_lb_d;
  logic [LB_W-1:0]  rd_lb_q, rd_lb_d;
  logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
  logic             intr_q, intr_d;

  logic             accept;
  logic             rd_cycle;
  logic [LB_W-1:0]  rd_lb1, rd_lb2;
  logic [23:0]      lb_data [NUM_LB];

  assign o_ready  = (total_cnt_q < FULL_LVL);
  assign accept   = i_pixel_valid && o_ready;
  assign rd_cycle = (state_q == RD_LINE);

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    rd_lb_d  = rd_lb_q;
    intr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (total_cnt_q >= RD_LVL) begin
          state_d = RD_LINE;
        end
      end
      RD_LINE: begin
        if (rd_cnt_q == LAST_COL) begin
          rd_cnt_d = '0;
          rd_lb_d  = rd_lb_q + 1'b1;
          state_d  = IDLE;
          intr_d   = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_lb_d     = wr_lb_q;
    total_cnt_d = total_cnt_q;
    if (accept) begin
      if (wr_cnt_q == LAST_COL) begin
        wr_cnt_d = '0;
        wr_lb_d  = wr_lb_q + 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    // A simultaneous write and read leave the fill level unchanged.
    case ({accept, rd_cycle})
      2'b10:   total_cnt_d = total_cnt_q + 1'b1;
      2'b01:   total_cnt_d = total_cnt_q - 1'b1;
      default: total_cnt_d = total_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_lb_q     <= '0;
      rd_lb_q     <= '0;
      total_cnt_q <= '0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_lb_q     <= wr_lb_d;
      rd_lb_q     <= rd_lb_d;
      total_cnt_q <= total_cnt_d;
      intr_q      <= intr_d;
    end
  end

  assign lb_data[0] = i_lb_data0;
  assign lb_data[1] = i_lb_data1;
  assign lb_data[2] = i_lb_data2;
  assign lb_data[3] = i_lb_data3;

  // A buffer is read when it is one of the three lines starting at rd_lb_q.
  for (genvar gi = 0; gi < NUM_LB; gi++) begin : g_lb
    logic [LB_W-1:0] age;
    assign age               = LB_W'(gi) - rd_lb_q;
    assign o_lb_wr_valid[gi] = accept && (wr_lb_q == LB_W'(gi));
    assign o_lb_rd_en[gi]    = rd_cycle && (age < LB_W'(3));
  end

  assign rd_lb1         = rd_lb_q + 1'b1;
  assign rd_lb2         = rd_lb_q + LB_W'(2);
  assign o_window       = {lb_data[rd_lb_q], lb_data[rd_lb1], lb_data[rd_lb2]};
  assign o_window_valid = rd_cycle;
  assign o_lb_wr_data   = i_pixel_data;
  assign o_intr         = intr_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl with a per-cycle reference model
// feeding an expected-output queue.
module tb_line_buffer_ctrl;

  localparam int W  = 128;
  localparam int TW = $clog2(4 * W + 1);
  localparam int CW = $clog2(W);
  localparam logic [23:0] LBC [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
  localparam logic [3:0] RDEN_TAB [4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        ready;
  logic [7:0]  wr_data;
  logic [3:0]  wr_valid;
  logic [3:0]  rd_en;
  logic [71:0] window;
  logic        wv;
  logic        intr;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.IMAGE_WIDTH(W), .NUM_LB(4)) dut (
    .clk           (clk),
    .rstN          (rst_n),
    .i_pixel_data  (pix_data),
    .i_pixel_valid (pix_valid),
    .o_ready       (ready),
    .o_lb_wr_data  (wr_data),
    .o_lb_wr_valid (wr_valid),
    .o_lb_rd_en    (rd_en),
    .i_lb_data0    (LBC[0]),
    .i_lb_data1    (LBC[1]),
    .i_lb_data2    (LBC[2]),
    .i_lb_data3    (LBC[3]),
    .o_window      (window),
    .o_window_valid(wv),
    .o_intr        (intr)
  );

  typedef struct {
    logic        ready;
    logic [3:0]  wr_valid;
    logic [3:0]  rd_en;
    logic        wv;
    logic [71:0] window;
    logic        intr;
    int          total;
    int          wr_cnt;
    int          rd_cnt;
  } exp_t;

  typedef struct {
    logic [3:0]  rd_en;
    logic [71:0] win;
  } line_t;

  exp_t  exp_q[$];
  line_t line_q[$];
  int checks   = 0;
  int failures = 0;

  int m_total = 0, m_wr_cnt = 0, m_wr_lb = 0, m_rd_cnt = 0, m_rd_lb = 0;
  bit m_reading = 0, m_intr = 0;

  // Drives one cycle, pushes the model's expected outputs, then advances the model.
  task automatic drive_cycle(input logic rn, input logic v, input logic [7:0] d);
    exp_t e;
    bit   acc, rd;
    int   old_total;
    @(posedge clk);
    #1;
    rst_n = rn; pix_valid = v; pix_data = d;
    e.ready    = (m_total < 4 * W);
    acc        = v && e.ready;
    rd         = m_reading;
    e.wr_valid = acc ? 4'(1 << m_wr_lb) : 4'b0000;
    e.rd_en    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (rd && (((k - m_rd_lb + 4) % 4) < 3)) e.rd_en[k] = 1'b1;
    end
    e.wv     = rd;
    e.window = {LBC[m_rd_lb], LBC[(m_rd_lb + 1) % 4], LBC[(m_rd_lb + 2) % 4]};
    e.intr   = m_intr;
    e.total  = m_total;
    e.wr_cnt = m_wr_cnt;
    e.rd_cnt = m_rd_cnt;
    exp_q.push_back(e);
    if (!rn) begin
      m_total = 0; m_wr_cnt = 0; m_wr_lb = 0; m_rd_cnt = 0; m_rd_lb = 0;
      m_reading = 0; m_intr = 0;
    end else begin
      old_total = m_total;
      if (acc && !rd) m_total++;
      else if (rd && !acc) m_total--;
      if (acc) begin
        m_wr_cnt++;
        if (m_wr_cnt == W) begin m_wr_cnt = 0; m_wr_lb = (m_wr_lb + 1) % 4; end
      end
      m_intr = 0;
      if (rd) begin
        m_rd_cnt++;
        if (m_rd_cnt == W) begin
          m_rd_cnt = 0; m_rd_lb = (m_rd_lb + 1) % 4; m_reading = 0; m_intr = 1;
        end
      end else if (old_total >= 3 * W) begin
        m_reading = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive_cycle(1'b0, 1'b0, 8'h00);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 8'h00);
      e = exp_q.pop_front();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", ready); end
      checks++; if (rd_en !== 4'b0000) begin failures++; $display("FAIL reset_rd_en got=%b exp=0000", rd_en); end
      checks++; if (wv !== 1'b0) begin failures++; $display("FAIL reset_window_valid got=%0b exp=0", wv); end
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL reset_intr got=%0b exp=0", intr); end
      checks++; if (wr_valid !== e.wr_valid) begin failures++; $display("FAIL reset_wr_valid got=%b exp=%b", wr_valid, e.wr_valid); end
      checks++; if (window !== e.window) begin failures++; $display("FAIL reset_window got=%h exp=%h", window, e.window); end
      checks++;
      if (dut.total_cnt_q !== TW'(0) || dut.wr_cnt_q !== CW'(0) || dut.rd_cnt_q !== CW'(0)) begin
        failures++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", dut.total_cnt_q, dut.wr_cnt_q, dut.rd_cnt_q);
      end
    end
    drive_cycle(1'b0, 1'b1, 8'h5a);
    e = exp_q.pop_front();
    checks++; if (wr_valid !== 4'b0001) begin failures++; $display("FAIL reset_accept_strobe got=%b exp=0001", wr_valid); end
    drive_cycle(1'b1, 1'b0, 8'h00);
    void'(exp_q.pop_front());
  endtask

  task automatic test_stream();
    exp_t e;
    int   gap, n;
    logic [3:0] exp_strobe;
    for (int i = 0; i < 3 * W; i++) begin
      drive_cycle(1'b1, 1'b1, 8'(i));
      e = exp_q.pop_front();
      exp_strobe = 4'(1 << (i / W));
      checks++; if (wr_valid !== exp_strobe) begin failures++; $display("FAIL stream_wr_valid px=%0d got=%b exp=%b", i, wr_valid, exp_strobe); end
      checks++; if (wr_data !== 8'(i)) begin failures++; $display("FAIL stream_wr_data px=%0d got=%h exp=%h", i, wr_data, 8'(i)); end
      checks++; if (wv !== 1'b0) begin failures++; $display("FAIL stream_early_window px=%0d got=%0b exp=0", i, wv); end
    end
    gap = 0;
    do begin
      drive_cycle(1'b1, 1'b0, 8'h00);
      e = exp_q.pop_front();
      gap++;
    end while (wv !== 1'b1 && gap < 8);
    checks++; if (gap != 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", gap); end
    n = 0;
    while (wv === 1'b1 && n < W + 4) begin
      n++;
      checks++; if (rd_en !== 4'b0111) begin failures++; $display("FAIL stream_rd_en got=%b exp=0111", rd_en); end
      checks++; if (window !== {LBC[0], LBC[1], LBC[2]}) begin failures++; $display("FAIL stream_window got=%h", window); end
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL stream_intr_early got=%0b exp=0", intr); end
      drive_cycle(1'b1, 1'b0, 8'h00);
      e = exp_q.pop_front();
    end
    checks++; if (n != W) begin failures++; $display("FAIL stream_read_len got=%0d exp=%0d", n, W); end
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL stream_intr got=%0b exp=1", intr); end
    checks++; if (dut.total_cnt_q !== TW'(2 * W)) begin failures++; $display("FAIL stream_total got=%0d exp=%0d", dut.total_cnt_q, 2 * W); end
    drive_cycle(1'b1, 1'b0, 8'h00);
    e = exp_q.pop_front();
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL stream_intr_width got=%0b exp=0", intr); end
    checks++; if (wv !== 1'b0) begin failures++; $display("FAIL stream_idle_after got=%0b exp=0", wv); end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    int   guard = 0;
    do begin
      drive_cycle(1'b1, 1'b1, 8'(guard));
      e = exp_q.pop_front();
      guard++;
    end while (wv !== 1'b1 && guard < 2 * W);
    checks++; if (wv !== 1'b1) begin failures++; $display("FAIL same_cycle_start got=%0b exp=1", wv); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_valid !== 4'b0001 || rd_en !== 4'b1110) begin failures++; $display("FAIL same_cycle_strobes got=%b/%b exp=0001/1110", wr_valid, rd_en); end
      checks++; if (dut.total_cnt_q !== TW'(3 * W + 1)) begin failures++; $display("FAIL same_cycle_total got=%0d exp=%0d", dut.total_cnt_q, 3 * W + 1); end
      checks++; if (dut.wr_cnt_q !== CW'(1 + i)) begin failures++; $display("FAIL same_cycle_wr_cnt got=%0d exp=%0d", dut.wr_cnt_q, 1 + i); end
      checks++; if (dut.rd_cnt_q !== CW'(i)) begin failures++; $display("FAIL same_cycle_rd_cnt got=%0d exp=%0d", dut.rd_cnt_q, i); end
      drive_cycle(1'b1, 1'b1, 8'(i));
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_five_lines();
    exp_t  e;
    line_t l;
    int    done = 0;
    drive_cycle(1'b0, 1'b0, 8'h00); void'(exp_q.pop_front());
    drive_cycle(1'b1, 1'b0, 8'h00); void'(exp_q.pop_front());
    line_q.delete();
    for (int k = 0; k < 5; k++) begin
      l.rd_en = RDEN_TAB[k % 4];
      l.win   = {LBC[k % 4], LBC[(k + 1) % 4], LBC[(k + 2) % 4]};
      line_q.push_back(l);
    end
    for (int c = 0; c < 3 * W + 5 * (W + 2) + 16 && done < 5; c++) begin
      drive_cycle(1'b1, 1'b1, 8'(c));
      e = exp_q.pop_front();
      checks++; if (wv !== e.wv) begin failures++; $display("FAIL lines_window_valid cyc=%0d got=%0b exp=%0b", c, wv, e.wv); end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL lines_ready cyc=%0d got=%0b exp=1", c, ready); end
      if (wv === 1'b1 && line_q.size() > 0) begin
        checks++;
        if (rd_en !== line_q[0].rd_en || window !== line_q[0].win) begin
          failures++; $display("FAIL lines_row_order line=%0d got=%b/%h exp=%b/%h", done, rd_en, window, line_q[0].rd_en, line_q[0].win);
        end
      end
      if (intr === 1'b1) begin
        done++;
        if (line_q.size() > 0) void'(line_q.pop_front());
      end
    end
    checks++; if (done != 5) begin failures++; $display("FAIL lines_count got=%0d exp=5", done); end
  endtask

  task automatic test_full();
    exp_t e;
    drive_cycle(1'b0, 1'b0, 8'h00); void'(exp_q.pop_front());
    drive_cycle(1'b1, 1'b0, 8'h00); void'(exp_q.pop_front());
    for (int g = 0; g < 3 * W + (W + 2) * (W + 1) + 100; g++) begin
      drive_cycle(1'b1, 1'b1, 8'(g));
      e = exp_q.pop_front();
      checks++; if (ready !== e.ready) begin failures++; $display("FAIL full_ready cyc=%0d got=%0b exp=%0b", g, ready, e.ready); end
      checks++; if (wr_valid !== e.wr_valid || rd_en !== e.rd_en) begin failures++; $display("FAIL full_strobes cyc=%0d got=%b/%b exp=%b/%b", g, wr_valid, rd_en, e.wr_valid, e.rd_en); end
      checks++; if (intr !== e.intr) begin failures++; $display("FAIL full_intr cyc=%0d got=%0b exp=%0b", g, intr, e.intr); end
      checks++; if (dut.total_cnt_q !== TW'(e.total)) begin failures++; $display("FAIL full_total cyc=%0d got=%0d exp=%0d", g, dut.total_cnt_q, e.total); end
      if (ready === 1'b0) break;
    end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_never_stalled got=%0b exp=0", ready); end
    checks++; if (dut.total_cnt_q !== TW'(4 * W)) begin failures++; $display("FAIL full_level got=%0d exp=%0d", dut.total_cnt_q, 4 * W); end
    checks++; if (wr_valid !== 4'b0000) begin failures++; $display("FAIL full_drop_strobe got=%b exp=0000", wr_valid); end
    checks++; if (wv !== 1'b1) begin failures++; $display("FAIL full_reading got=%0b exp=1", wv); end
    drive_cycle(1'b1, 1'b0, 8'h00);
    e = exp_q.pop_front();
    checks++; if (dut.total_cnt_q !== TW'(4 * W - 1)) begin failures++; $display("FAIL full_drop_total got=%0d exp=%0d", dut.total_cnt_q, 4 * W - 1); end
    checks++; if (dut.wr_cnt_q !== CW'(0)) begin failures++; $display("FAIL full_drop_wr_cnt got=%0d exp=0", dut.wr_cnt_q); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL full_ready_return got=%0b exp=1", ready); end
  endtask

  task automatic test_reset_mid_line();
    exp_t e;
    int   guard = 0;
    drive_cycle(1'b0, 1'b0, 8'h00); void'(exp_q.pop_front());
    drive_cycle(1'b1, 1'b0, 8'h00); void'(exp_q.pop_front());
    do begin
      drive_cycle(1'b1, 1'b1, 8'(guard));
      e = exp_q.pop_front();
      guard++;
    end while (wv !== 1'b1 && guard < 3 * W + 8);
    checks++; if (wv !== 1'b1) begin failures++; $display("FAIL midrst_start got=%0b exp=1", wv); end
    for (int i = 1; i < 50; i++) begin
      drive_cycle(1'b1, 1'b1, 8'(i));
      e = exp_q.pop_front();
    end
    drive_cycle(1'b0, 1'b1, 8'hee);
    e = exp_q.pop_front();
    checks++; if (dut.rd_cnt_q !== CW'(50) || wv !== 1'b1) begin failures++; $display("FAIL midrst_position got=%0d/%0b exp=50/1", dut.rd_cnt_q, wv); end
    drive_cycle(1'b1, 1'b0, 8'h00);
    e = exp_q.pop_front();
    checks++; if (wv !== 1'b0 || rd_en !== 4'b0000) begin failures++; $display("FAIL midrst_read_stop got=%0b/%b exp=0/0000", wv, rd_en); end
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL midrst_intr got=%0b exp=0", intr); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0b exp=1", ready); end
    checks++;
    if (dut.total_cnt_q !== TW'(0) || dut.wr_cnt_q !== CW'(0) || dut.rd_cnt_q !== CW'(0) ||
        dut.wr_lb_q !== 2'd0 || dut.rd_lb_q !== 2'd0) begin
      failures++; $display("FAIL midrst_counters got=%0d/%0d/%0d/%0d/%0d exp=0", dut.total_cnt_q, dut.wr_cnt_q, dut.rd_cnt_q, dut.wr_lb_q, dut.rd_lb_q);
    end
    for (int i = 0; i < W + 4; i++) begin
      drive_cycle(1'b1, 1'b0, 8'h00);
      e = exp_q.pop_front();
      checks++; if (intr !== 1'b0 || wv !== 1'b0) begin failures++; $display("FAIL midrst_quiet cyc=%0d got=%0b/%0b exp=0/0", i, intr, wv); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    test_reset();
    test_stream();
    test_same_cycle();
    test_five_lines();
    test_full();
    test_reset_mid_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 The block SHALL take parameter IMAGE_WIDTH, default 512 (from definitions_pkg), which is the pixels per image line and per line buffer.
REQ-002 The block SHALL take parameter NUM_LB, fixed at 4, which is the number of downstream line buffers managed.
REQ-003 The ports SHALL be, in order:
  - clk  in  1  clock
  - rstN  in  1  reset, synchronous, active-low
  - i_pixel_data  in  8  incoming pixel
  - i_pixel_valid  in  1  pixel offered
  - o_ready  out  1  pixel will be accepted this cycle
  - o_lb_wr_data  out  8  pixel to line buffers
  - o_lb_wr_valid  out  4  one-hot write strobe, bit k = buffer k
  - o_lb_rd_en  out  4  per-buffer read advance
  - i_lb_data0..i_lb_data3  in  24 each  prefetched 3-pixel row segment from buffer k
  - o_window  out  72  3x3 window
  - o_window_valid  out  1  o_window valid this cycle
  - o_intr  out  1  one-cycle pulse when a line has been fully consumed

Function
REQ-004 Accept SHALL be defined as i_pixel_valid && o_ready.
REQ-005 o_ready SHALL be asserted iff totalCnt < 4*IMAGE_WIDTH; o_ready is combinational from registered state.
REQ-006 o_lb_wr_data SHALL equal i_pixel_data combinationally.
REQ-007 o_lb_wr_valid SHALL be the one-hot of wrLb on accept, and 4'b0000 otherwise.
REQ-008 A pixel offered while o_ready=0 SHALL be dropped: no strobe and no counter change.
REQ-009 wrCnt (0..IMAGE_WIDTH-1) SHALL increment on each accept; on accept with wrCnt==IMAGE_WIDTH-1 it SHALL wrap to 0 and wrLb SHALL advance mod 4.
REQ-010 totalCnt (12 bits, 0..2048) SHALL update as follows:
  - +1 on accept without read
  - -1 on read cycle without accept
  - unchanged when both occur in the same cycle
REQ-011 FSM states SHALL be IDLE and RD_LINE.
REQ-012 IDLE -> RD_LINE SHALL occur when totalCnt >= 3*IMAGE_WIDTH; otherwise the FSM stays in IDLE.
REQ-013 In RD_LINE each cycle SHALL be a read cycle.
REQ-014 rdCnt SHALL increment on each read cycle; at rdCnt==IMAGE_WIDTH-1:
  - rdCnt wraps to 0
  - rdLb advances mod 4
  - the FSM returns to IDLE
  - o_intr is registered high for exactly the next cycle
REQ-015 Each RD_LINE visit SHALL last exactly IMAGE_WIDTH cycles, followed by at least one IDLE cycle.
REQ-016 o_lb_rd_en SHALL assert bits rdLb, (rdLb+1)%4 and (rdLb+2)%4 during read cycles; the remaining bit and all bits in IDLE SHALL be 0.
REQ-017 o_window SHALL be the combinational concatenation {i_lb_data[rdLb], i_lb_data[(rdLb+1)%4], i_lb_data[(rdLb+2)%4]}, with the oldest line in bits [71:48].
REQ-018 o_window SHALL be driven in every state.
REQ-019 o_window_valid SHALL equal (state==RD_LINE), combinationally, in the same cycle as o_lb_rd_en.
REQ-020 Window latency: when the 1536th pixel (IMAGE_WIDTH=512) is accepted in cycle N with no prior reads, o_window_valid SHALL first assert in cycle N+2.
REQ-021 Writes SHALL continue during RD_LINE into buffer wrLb, which is never one of the three buffers being read while the upstream respects o_ready.

Reset
REQ-022 On rstN=0 at a clock edge, the following SHALL be cleared:
  - wrLb, rdLb, wrCnt, rdCnt, totalCnt = 0
  - state = IDLE
  - o_intr = 0
REQ-023 During and after reset, combinational outputs SHALL follow from the cleared state: o_lb_wr_valid=0 unless accept, o_lb_rd_en=0, o_window_valid=0, o_ready=1.
REQ-024 Reset asserted mid-RD_LINE SHALL abort the line immediately with no o_intr pulse.

Verification
REQ-025 Reset then stream 1536 pixels back-to-back -> o_lb_wr_valid sequences 0001 (512 cycles), 0010, 0100; o_window_valid first high 2 cycles after the last accept; o_lb_rd_en=0111 for exactly 512 cycles; o_intr high one cycle after; totalCnt=1024.
REQ-026 Drive 2048 pixels with no reads possible (hold before threshold is impossible, so stream continuously) -> o_ready deasserts exactly when totalCnt=2048; an offered pixel while o_ready=0 produces o_lb_wr_valid=0000 and totalCnt is unchanged.
REQ-027 Accept and read in the same cycle -> totalCnt unchanged; wrCnt and rdCnt both advance.
REQ-028 Run 5 full lines -> rdLb sequence 0,1,2,3,0; o_lb_rd_en sequence 0111, 1110, 1101, 1011, 0111; o_window row order rotates accordingly (checked with distinct constants 0x111111..0x444444 on i_lb_data0..3).
REQ-029 Assert rstN=0 at rdCnt=200 -> next cycle state=IDLE, o_lb_rd_en=0, o_window_valid=0, o_intr=0, o_ready=1, all counters 0.
